// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: opcodes, FSM states, IR field
// positions and instruction decode helpers.
package cpu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int RC_HI  = 18;
   localparam int RC_LO  = 15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6
   } state_t;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic is_legal(
      input logic [4:0]  op,
      input logic [3:0]  ra,
      input logic [3:0]  rb,
      input logic [3:0]  rc,
      input int unsigned nregs
   );
      logic op_ok;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
         OP_ROL, OP_MUL, OP_DIV: op_ok = 1'b1;
         default:                op_ok = 1'b0;
      endcase
      return op_ok
         && (32'(ra) < nregs)
         && (32'(rb) < nregs)
         && (32'(rc) < nregs);
   endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot strobe; indices past NUM_REGS
// decode to all zeros.
module reg_onehot_dec #(
   parameter int NUM_REGS = 16
) (
   input  logic [3:0]          idx,
   input  logic                en,
   output logic [NUM_REGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (idx == 4'(i)))
            onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute control sequencer for the bus datapath with
// memory-latency handshake and completed-instruction counter.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int OP_W     = 5,
   parameter int DATA_W   = 32,
   parameter int CNT_W    = 16
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                run,
   input  logic [DATA_W-1:0]   ir,
   input  logic                mem_done,
   output logic                pc_out,
   output logic                mar_in,
   output logic                inc_pc,
   output logic                pc_in,
   output logic                read,
   output logic                mdr_in,
   output logic                mdr_out,
   output logic                ir_in,
   output logic                y_in,
   output logic                zlow_in,
   output logic                zhigh_in,
   output logic                zlo_out,
   output logic                zhi_out,
   output logic                hi_in,
   output logic                lo_in,
   output logic [NUM_REGS-1:0] reg_in,
   output logic [NUM_REGS-1:0] reg_out,
   output logic [OP_W-1:0]     alu_op,
   output logic                busy,
   output logic                done,
   output logic                illegal,
   output logic [CNT_W-1:0]    instr_count
);

   state_t     state, state_nx;
   logic [4:0] opc;
   logic [3:0] ra, rb, rc;
   logic [3:0] rout_idx;
   logic       rin_en, rout_en;
   logic       legal, md;
   logic       unused_ir;

   assign opc       = ir[OPC_HI:OPC_LO];
   assign ra        = ir[RA_HI:RA_LO];
   assign rb        = ir[RB_HI:RB_LO];
   assign rc        = ir[RC_HI:RC_LO];
   assign unused_ir = ^ir[RC_LO-1:0];
   assign legal     = is_legal(opc, ra, rb, rc, NUM_REGS);
   assign md        = is_muldiv(opc);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clock) begin
      if (clear) begin
         state       <= S_IDLE;
         instr_count <= '0;
      end else begin
         state <= state_nx;
         if (done)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

   always_comb begin
      state_nx = state;
      pc_out   = 1'b0;
      mar_in   = 1'b0;
      inc_pc   = 1'b0;
      pc_in    = 1'b0;
      read     = 1'b0;
      mdr_in   = 1'b0;
      mdr_out  = 1'b0;
      ir_in    = 1'b0;
      y_in     = 1'b0;
      zlow_in  = 1'b0;
      zhigh_in = 1'b0;
      zlo_out  = 1'b0;
      zhi_out  = 1'b0;
      hi_in    = 1'b0;
      lo_in    = 1'b0;
      alu_op   = '0;
      done     = 1'b0;
      illegal  = 1'b0;
      rin_en   = 1'b0;
      rout_en  = 1'b0;
      rout_idx = rb;
      unique case (state)
         S_IDLE: begin
            if (run)
               state_nx = S_T0;
         end
         S_T0: begin
            pc_out   = 1'b1;
            mar_in   = 1'b1;
            inc_pc   = 1'b1;
            zlow_in  = 1'b1;
            state_nx = S_T1;
         end
         S_T1: begin
            zlo_out = 1'b1;
            pc_in   = 1'b1;
            read    = 1'b1;
            mdr_in  = 1'b1;
            if (mem_done)
               state_nx = S_T2;
         end
         S_T2: begin
            mdr_out  = 1'b1;
            ir_in    = 1'b1;
            state_nx = S_T3;
         end
         S_T3: begin
            if (!legal) begin
               illegal  = 1'b1;
               state_nx = S_IDLE;
            end else begin
               rout_en  = 1'b1;
               y_in     = 1'b1;
               state_nx = S_T4;
            end
         end
         S_T4: begin
            rout_en  = 1'b1;
            rout_idx = rc;
            alu_op   = OP_W'(opc);
            zlow_in  = 1'b1;
            zhigh_in = md;
            state_nx = S_T5;
         end
         S_T5: begin
            zlo_out = 1'b1;
            if (md) begin
               lo_in    = 1'b1;
               state_nx = S_T6;
            end else begin
               rin_en   = 1'b1;
               done     = 1'b1;
               state_nx = run ? S_T0 : S_IDLE;
            end
         end
         S_T6: begin
            zhi_out  = 1'b1;
            hi_in    = 1'b1;
            done     = 1'b1;
            state_nx = run ? S_T0 : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   reg_onehot_dec #(.NUM_REGS(NUM_REGS)) u_reg_in_dec (
      .idx    (ra),
      .en     (rin_en),
      .onehot (reg_in)
   );

   reg_onehot_dec #(.NUM_REGS(NUM_REGS)) u_reg_out_dec (
      .idx    (rout_idx),
      .en     (rout_en),
      .onehot (reg_out)
   );

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Parametrised control-unit sequencer for the bus datapath. Fetches an instruction (T0–T2), then executes three-register ALU, shift, rotate, MUL and DIV operations (T3–T6), driving one-hot register strobes, ALU opcode and bus enables. Handles variable memory latency with a read handshake and counts completed instructions. Sits between the memory interface and the `bus` datapath, replacing hand-driven control sequences.

## Interface
- `NUM_REGS`, 16: general registers (≤16); `reg_in`/`reg_out` width.
- `OP_W`, 5: opcode / `alu_op` width.
- `DATA_W`, 32: IR width.
- `CNT_W`, 16: instruction counter width.

- `clock`  in  1  single clock, all state on posedge.
- `clear`  in  1  reset, synchronous, active-high.
- `run`  in  1  start/continue; sampled in IDLE and on instruction completion.
- `ir`  in  DATA_W  IR register contents. Opcode `ir[31:27]`, ra `ir[26:23]`, rb `ir[22:19]`, rc `ir[18:15]`.
- `mem_done`  in  1  memory read data valid on `Mdatain` this cycle.
- `pc_out`, `mar_in`, `inc_pc`, `pc_in`, `read`, `mdr_in`, `mdr_out`, `ir_in`, `y_in`, `zlow_in`, `zhigh_in`, `zlo_out`, `zhi_out`, `hi_in`, `lo_in`  out  1 each  datapath strobes.
- `reg_in`, `reg_out`  out  NUM_REGS  one-hot register strobes.
- `alu_op`  out  OP_W  ALU operation.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse in the final execute state.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.
- `instr_count`  out  CNT_W  completed-instruction count.

## Operation
- Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000.
- An instruction is illegal if its opcode is not in this list, or if any of ra/rb/rc ≥ NUM_REGS.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- Outputs are Moore-decoded from the state and `ir` fields. Every strobe not listed for a state is 0.
  - IDLE: all 0. Go to T0 when `run`=1.
  - T0: `pc_out`, `mar_in`, `inc_pc`, `zlow_in`.
  - T1: `zlo_out`, `pc_in`, `read`, `mdr_in`. Remain in T1 while `mem_done`=0; all four strobes are held during the wait. Go to T2 on `mem_done`=1.
  - T2: `mdr_out`, `ir_in`.
  - T3: `reg_out[rb]`, `y_in`. If the instruction is illegal, instead pulse `illegal` with no strobes and go to IDLE.
  - T4: `reg_out[rc]`, `alu_op`=opcode, `zlow_in`. MUL/DIV also assert `zhigh_in`. `alu_op`=0 in all other states.
  - T5, ALU ops: `zlo_out`, `reg_in[ra]`, `done`.
  - T5, MUL/DIV: `zlo_out`, `lo_in`.
  - T6 (MUL/DIV only): `zhi_out`, `hi_in`, `done`.
- On completion (the `done` state): go to T0 if `run`=1, else IDLE. `instr_count` increments by 1 and wraps modulo 2^CNT_W.
- Deasserting `run` mid-instruction has no effect until completion.
- ra=rb=rc is permitted.
- `reg_in` and `reg_out` are never both asserted in the same cycle.

## Timing
- Reset: `clear`=1 at a posedge puts the block in IDLE and sets `instr_count`=0 on the next cycle, from any state. This includes a T1 memory wait.
  - `clear` dominates `run` and `mem_done`.
  - Every output is 0 in reset/IDLE.
- Latency, with `mem_done` tied high:
  - `run` sampled in IDLE, T0 on the next cycle.
  - ALU op: 6 cycles T0–T5.
  - MUL/DIV: 7 cycles.
  - Each low cycle of `mem_done` in T1 adds one cycle.
- Back-to-back: T0 of the next instruction directly follows the `done` cycle, with no bubble.
- `ir` is sampled from T3 onward; IR updates at the end of T2.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants;
  - the state encoding;
  - IR field bit positions;
  - the `is_legal` and `is_muldiv` decode functions.
- Sub-module `reg_onehot_dec`: 4-bit index plus enable to NUM_REGS one-hot, with all-zero output for out-of-range indices. It is instantiated twice, for `reg_in` and `reg_out`.

## Test plan
- Reset: `clear`=1 for 2 cycles while in T3 → all outputs 0 on the next cycle, `busy`=0, `instr_count`=0.
- SHR, `ir`=32'h389A8000, `mem_done`=1, one-cycle `run` pulse → states T0..T5, then IDLE.
  - T3: `reg_out`=16'h0008.
  - T4: `reg_out`=16'h0020, `alu_op`=5'b00111.
  - T5: `reg_in`=16'h0002 with `done`.
  - After: `instr_count`=1.
- Memory wait: `mem_done` low for 3 cycles in T1 → T1 strobes held for 4 cycles, instruction takes 9 cycles.
- MUL, `ir`=32'h78120000 → T4 asserts `zlow_in` and `zhigh_in`; T5 asserts `lo_in`; T6 asserts `hi_in` with `done`; `reg_in` stays 0 throughout.
- Illegal: opcode 11111 → `illegal` pulses in the T3 cycle, with no `y_in`/`reg_out`. Next state IDLE; `instr_count` unchanged.
- Back-to-back: `run` held high for two SHRs with CNT_W=2 and the count starting at 3 → second T0 immediately after the first T5; `instr_count` goes 3→0→1.
